// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
//   Clock-enable controller for the single-cycle CPU. It derives a 1 ms tick
//   from the board clock and debounces the step button on that tick. It then
//   issues one-cycle CPU enables in single-step, slow-run or full-speed mode,
//   and parks in HALTED when the CPU requests a halt. The CPU stays on i_clk
//   and is qualified by o_cpu_ce; no derived clocks are produced.
//
// Ports
//   i_clk         board clock, rising edge
//   i_rst         synchronous active-high reset
//   i_btn_step    raw step button (asynchronous, bouncing)
//   i_sw_run      run switch (already synchronised)
//   i_sw_fast     in RUN: 1 = full speed, 0 = slow run
//   i_halt_req    CPU halt request, level
//   o_cpu_ce      registered CPU clock enable
//   o_tick_1ms    registered one-cycle pulse every TICK_DIV cycles
//   o_state       FSM state
//   o_step_count  number of o_cpu_ce high cycles since reset (wraps)
//
// state  | meaning
// IDLE   | waiting for a step press or the run switch
// STEP   | single enable issued, return to IDLE next edge
// RUN    | free running, full speed or one enable per SLOW_MS ticks
// HALTED | CPU halted; held here until the run switch is released
module cpu_step_ctrl #(
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SLOW_MS     = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_step,
  input  logic        i_sw_run,
  input  logic        i_sw_fast,
  input  logic        i_halt_req,
  output logic        o_cpu_ce,
  output logic        o_tick_1ms,
  output logic [1:0]  o_state,
  output logic [15:0] o_step_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_RUN    = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [15:0] TC_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DC_LAST = 8'(DEBOUNCE_MS - 1);
  localparam logic [9:0]  SC_LAST = 10'(SLOW_MS - 1);

  logic [15:0] r_tcnt;
  logic        r_tick;
  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_dcnt;
  logic        r_btn_db;
  logic        r_btn_db_d;
  logic [9:0]  r_scnt;
  state_t      r_state;
  logic        r_cpu_ce;
  logic [15:0] r_step_count;
  logic        w_step_evt;

  // Only a rising debounced level is a press; the release is ignored.
  assign w_step_evt = r_btn_db & ~r_btn_db_d;

  // Tick generator
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tcnt <= (r_tcnt == TC_LAST) ? 16'd0 : r_tcnt + 16'd1;
      r_tick <= (r_tcnt == TC_LAST);
    end
  end

  // Synchroniser and tick-based debouncer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_dcnt     <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
    end else begin
      r_sync1    <= i_btn_step;
      r_sync2    <= r_sync1;
      r_btn_db_d <= r_btn_db;
      if (r_tick) begin
        if (r_sync2 != r_btn_db) begin
          // The DEBOUNCE_MS-th consecutive differing tick accepts the level.
          if (r_dcnt == DC_LAST) begin
            r_btn_db <= r_sync2;
            r_dcnt   <= '0;
          end else begin
            r_dcnt <= r_dcnt + 8'd1;
          end
        end else begin
          r_dcnt <= '0;
        end
      end
    end
  end

  // Sequencing FSM with registered enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cpu_ce <= 1'b0;
      r_scnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cpu_ce <= 1'b0;
          if (i_sw_run && !i_halt_req) begin
            r_state <= S_RUN;
            r_scnt  <= '0;
          end else if (w_step_evt) begin
            r_state  <= S_STEP;
            r_cpu_ce <= 1'b1;
          end
        end
        S_STEP: begin
          r_state  <= S_IDLE;
          r_cpu_ce <= 1'b0;
        end
        S_RUN: begin
          if (i_halt_req) begin
            r_state  <= S_HALTED;
            r_cpu_ce <= 1'b0;
          end else if (!i_sw_run) begin
            r_state  <= S_IDLE;
            r_cpu_ce <= 1'b0;
          end else if (i_sw_fast) begin
            r_cpu_ce <= 1'b1;
          end else begin
            r_cpu_ce <= r_tick && (r_scnt == SC_LAST);
            if (r_tick) begin
              r_scnt <= (r_scnt == SC_LAST) ? 10'd0 : r_scnt + 10'd1;
            end
          end
        end
        S_HALTED: begin
          r_cpu_ce <= 1'b0;
          if (!i_sw_run) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cpu_ce <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_count <= '0;
    end else if (r_cpu_ce) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign o_cpu_ce     = r_cpu_ce;
  assign o_tick_1ms   = r_tick;
  assign o_state      = r_state;
  assign o_step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl. A reference model written from the behavioural
// rules predicts every output after every clock edge; the expectation is queued
// and a monitor on the falling edge compares it with the DUT outputs.
module tb_cpu_step_ctrl;

  localparam int TD = 10;
  localparam int DB = 3;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst, btn, run, fast, halt;
  logic        cpu_ce, tick_1ms;
  logic [1:0]  state;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.TICK_DIV(TD), .DEBOUNCE_MS(DB), .SLOW_MS(SL)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_step(btn), .i_sw_run(run),
    .i_sw_fast(fast), .i_halt_req(halt), .o_cpu_ce(cpu_ce),
    .o_tick_1ms(tick_1ms), .o_state(state), .o_step_count(step_count)
  );

  typedef struct {
    bit       ce;
    bit       tick;
    bit [1:0] st;
    int       cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, all as plain integers / bits.
  int m_edges;      // clock edges since reset was released
  bit m_s1, m_s2;   // button as seen one and two edges ago
  bit m_db, m_dbp;  // accepted button level, and its value one edge earlier
  int m_dticks;     // consecutive ticks on which the sample disagreed with m_db
  int m_slow_ticks; // ticks seen in slow RUN since entering RUN
  bit m_ce, m_tick;
  int m_st;         // 0 idle, 1 step, 2 run, 3 halted
  int m_cnt;

  task automatic model_edge(input bit r, input bit b, input bit rn, input bit f, input bit h);
    bit evt, n_ce, n_db;
    int n_st;
    if (r) begin
      m_edges = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_dticks = 0;
      m_slow_ticks = 0; m_ce = 0; m_tick = 0; m_st = 0; m_cnt = 0;
      return;
    end
    evt  = m_db && !m_dbp;
    n_st = m_st;
    n_ce = 0;
    case (m_st)
      0: if (rn && !h) begin n_st = 2; m_slow_ticks = 0; end
         else if (evt) begin n_st = 1; n_ce = 1; end
      1: n_st = 0;
      2: if (h) n_st = 3;
         else if (!rn) n_st = 0;
         else if (f) n_ce = 1;
         else if (m_tick) begin
           n_ce = ((m_slow_ticks % SL) == SL - 1);
           m_slow_ticks++;
         end
      default: if (!rn) n_st = 0;
    endcase
    m_cnt = (m_cnt + (m_ce ? 1 : 0)) % 65536;
    n_db = m_db;
    if (m_tick) begin
      if (m_s2 != m_db) begin
        m_dticks++;
        if (m_dticks == DB) begin n_db = m_s2; m_dticks = 0; end
      end else begin
        m_dticks = 0;
      end
    end
    m_dbp = m_db;
    m_db  = n_db;
    m_s2  = m_s1;
    m_s1  = b;
    m_edges++;
    m_tick = ((m_edges % TD) == 0);
    m_ce   = n_ce;
    m_st   = n_st;
  endtask

  task automatic cyc(input bit r);
    exp_t e;
    rst = r;
    model_edge(r, btn, run, fast, halt);
    e.ce = m_ce; e.tick = m_tick; e.st = 2'(m_st); e.cnt = m_cnt;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("cpu_ce", int'(cpu_ce), int'(e.ce));
      check("tick_1ms", int'(tick_1ms), int'(e.tick));
      check("state", int'(state), int'(e.st));
      check("step_count", int'(step_count), e.cnt);
    end
  end

  initial begin
    int guard;
    rst = 1; btn = 0; run = 0; fast = 0; halt = 0;
    repeat (3) cyc(1'b1);

    // Idle: ticks only.
    idle_n(100);

    // Clean press then release, then a chattering button.
    btn = 1; idle_n(60);
    btn = 0; idle_n(20);
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) btn = ~btn;
      cyc(1'b0);
    end
    btn = 0; idle_n(50);

    // Slow run, then full speed, then drop the run switch.
    run = 1; fast = 0; idle_n(200);
    fast = 1; idle_n(20);
    run = 0; idle_n(5);

    // Halt during fast run; button ignored while halted.
    run = 1; fast = 1; idle_n(10);
    halt = 1; cyc(1'b0);
    halt = 0; idle_n(5);
    btn = 1; idle_n(60);
    btn = 0; idle_n(40);
    run = 0; idle_n(5);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(24) == 0) btn = ~btn;
      if ($urandom_range(59) == 0) run = ~run;
      if ($urandom_range(39) == 0) fast = ~fast;
      halt = ($urandom_range(79) == 0);
      cyc(1'b0);
    end
    halt = 0; run = 0; btn = 0; idle_n(10);

    // Random-length button presses from IDLE.
    for (int p = 0; p < 4; p++) begin
      btn = 1; idle_n(int'($urandom_range(25, 60)));
      btn = 0; idle_n(int'($urandom_range(30, 60)));
    end

    // Drive step_count to 0xFFFF with full-speed running, then wrap.
    run = 1; fast = 1;
    guard = 0;
    while (m_cnt != 65535 && guard < 70000) begin
      cyc(1'b0);
      guard++;
    end
    n_checks++;
    if (m_cnt != 65535) begin
      n_fail++;
      $display("FAIL wrap_reach: model count %0d expected 65535 within budget", m_cnt);
    end
    idle_n(3);

    // Reset mid fast run.
    cyc(1'b1);
    cyc(1'b0);
    idle_n(5);
    run = 0; idle_n(3);

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
